dp_ram_pipe: RTL and testbench
==============================

# dp_ram_pipe

Parametrised true dual-port RAM: successor to the existing single-cycle dual-port RAM. Adds per-port enables, byte-lane write enables and a selectable read latency of 1 or 2. Same-address collisions are resolved per byte under a programmable priority. A built-in initialisation sequencer clears every word after reset, so the RAM never powers up with undefined contents. Sits between two independent masters (e.g. a producer and a consumer engine) sharing one storage array on a common clock.

## Interface
- DATA_WIDTH, 8: word width; must be a multiple of 8 (NB = DATA_WIDTH/8 byte lanes).
- ADDR_WIDTH, 4: address width; DEPTH = 2**ADDR_WIDTH.
- RD_LATENCY, 1: 1 or 2 cycles from request edge to data; any other value is a fatal elaboration error.
- RDW_MODE, 0: same-port read-during-write; 0 = READ_FIRST (old word), 1 = WRITE_FIRST (new word).
- WR_PRIORITY, 1: byte-lane winner on same-address dual write; 1 = port B, 0 = port A.
- INIT_VALUE, '0: word written to every address by the init sequencer.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- busy  out  1  high while init sequencer runs; both ports are ignored.
- enA  in  1  port A operation request.
- wrA  in  1  1 = write, 0 = read (qualified by enA).
- beA  in  NB  byte-lane write enables (ignored on reads).
- addrA  in  ADDR_WIDTH  port A address.
- dataA_in  in  DATA_WIDTH  port A write data.
- dataA_out  out  DATA_WIDTH  port A read data.
- validA  out  1  dataA_out carries the result of an accepted op.
- enB, wrB, beB, addrB, dataB_in, dataB_out, validB: identical for port B.
- coll  out  1  collision pulse (only with macro, else tied 0).
- coll_cnt  out  16  saturating collision count (only with macro, else tied 0).

## Operation
- Init FSM states: INIT, READY.
  - Reset: state INIT, init pointer 0, busy 1.
  - INIT writes INIT_VALUE to address = pointer once per cycle and increments the pointer.
  - After writing DEPTH-1, the next state is READY and busy goes 0.
  - Init takes exactly DEPTH cycles after rst_n rises.
  - Reset asserted mid-init restarts the sequence from address 0.
- Op accepted when enX=1 and busy=0.
  - Read: returns mem[addrX].
  - Write: updates only the lanes with beX set. A write with beX=0 is a no-op on memory but still produces output and valid.
- Write output (same port), per RDW_MODE:
  - READ_FIRST: dataX_out returns the pre-write word.
  - WRITE_FIRST: dataX_out returns the post-merge word, including the other port's winning lanes on collision.
- Cross-port read of an address the other port writes in the same cycle always returns the pre-write word.
- Dual write, same address:
  - A lane set by only one port takes that port's byte.
  - A lane set by both ports takes the byte of the WR_PRIORITY port.
- Collision: both ops accepted, addrA==addrB, and at least one is a write.
- No accepted op: dataX_out holds its last value; validX=0.

## Timing
- Reset values: dataA_out=dataB_out=0, validA=validB=0, busy=1, coll=0, coll_cnt=0, all pipeline registers 0.
- RD_LATENCY=1: request sampled at edge N; data and valid registered at edge N; visible during cycle N+1.
- RD_LATENCY=2: one extra output register; visible one cycle later.
- The valid pipeline matches the data pipeline depth.
- Memory writes commit at the request edge; a read issued at edge N+1 sees them.
- Full throughput: one op per port per cycle, back-to-back, with no bubbles.
- Address wrap is natural modulo DEPTH; no range checking.
- Ops requested while busy=1 are dropped and produce no valid.

## Configuration
- DP_RAM_PIPE_COLL_STATS_EN defined:
  - coll is registered high in the cycle after a collision edge.
  - coll_cnt increments on each collision and saturates at 16'hFFFF.
  - coll_cnt is cleared only by rst_n.
- Undefined: coll and coll_cnt are constant 0, and the detection logic is absent.
- Collision resolution behaviour is identical either way.

## Structure
- Package dp_ram_pipe_pkg holds:
  - typedef for the init FSM state enum (INIT, READY);
  - localparam encodings RDW_READ_FIRST/RDW_WRITE_FIRST and PRIO_A/PRIO_B;
  - the function that performs the byte-lane merge.
- Sub-module dp_ram_pipe_outreg: per-port output/valid pipeline parametrised by RD_LATENCY; instantiated twice.

## Test plan
- Release rst_n -> busy high for exactly 16 cycles (ADDR_WIDTH=4); then reads of all addresses return 8'h00 with validA one cycle after request.
- Assert rst_n low at init cycle 7 -> busy stays high; the sequence restarts and takes 16 full cycles after release.
- A writes 8'hA1 to 0x1; B reads 0x1 next cycle -> dataB_out=8'hA1.
- Same cycle, A writes 8'hC3 to 0x3 while B reads 0x3 (old 8'h00) -> dataB_out=8'h00; coll pulses and coll_cnt=1 with macro.
- DATA_WIDTH=16, WR_PRIORITY=1, both write 0x6:
  - A: 16'hF6F6 with be=2'b11; B: 16'h1717 with be=2'b01.
  - Memory becomes 16'hF617.
  - WRITE_FIRST: both outputs show 16'hF617.
  - READ_FIRST: both outputs show the prior word.
- RD_LATENCY=2: B reads 0x5 on four back-to-back cycles -> four valid beats starting two cycles after the first request, with no gaps.

Source files
------------

// File: rtl/dp_ram_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram_pipe_pkg
// Desc     : Shared types, encodings and byte-lane merge helper for dp_ram_pipe.
// Revision : 1.0
// ============================================================================
package dp_ram_pipe_pkg;

   typedef enum logic [0:0] {
      INIT  = 1'b0,
      READY = 1'b1
   } init_state_e;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;

   localparam int PRIO_A = 0;
   localparam int PRIO_B = 1;

   // Resolves one byte lane given which ports write it this cycle.
   function automatic logic [7:0] merge_byte(
      input logic [7:0] old_byte,
      input logic [7:0] a_byte,
      input logic       a_en,
      input logic [7:0] b_byte,
      input logic       b_en,
      input logic       b_wins
   );
      logic [7:0] res;
      res = old_byte;
      if (a_en && b_en) begin
         res = b_wins ? b_byte : a_byte;
      end else if (a_en) begin
         res = a_byte;
      end else if (b_en) begin
         res = b_byte;
      end
      return res;
   endfunction

endpackage : dp_ram_pipe_pkg
`default_nettype wire

// File: rtl/dp_ram_pipe_outreg.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram_pipe_outreg
// Desc     : Per-port read-data/valid pipeline, one or two register stages.
// Revision : 1.0
// ============================================================================
module dp_ram_pipe_outreg #(
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  vld_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  vld_out,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic                  s1_vld_q;
   logic                  s1_vld_d;
   logic [DATA_WIDTH-1:0] s1_data_q;
   logic [DATA_WIDTH-1:0] s1_data_d;

   // Data only moves with a valid beat so the output holds between ops.
   always_comb begin
      s1_vld_d  = vld_in;
      s1_data_d = vld_in ? data_in : s1_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_data_q <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_data_q <= s1_data_d;
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  s2_vld_q;
         logic                  s2_vld_d;
         logic [DATA_WIDTH-1:0] s2_data_q;
         logic [DATA_WIDTH-1:0] s2_data_d;

         always_comb begin
            s2_vld_d  = s1_vld_q;
            s2_data_d = s1_vld_q ? s1_data_q : s2_data_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_vld_q  <= 1'b0;
               s2_data_q <= '0;
            end else begin
               s2_vld_q  <= s2_vld_d;
               s2_data_q <= s2_data_d;
            end
         end

         assign vld_out  = s2_vld_q;
         assign data_out = s2_data_q;
      end else begin : g_lat1
         assign vld_out  = s1_vld_q;
         assign data_out = s1_data_q;
      end
   endgenerate

endmodule : dp_ram_pipe_outreg
`default_nettype wire

// File: rtl/dp_ram_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dp_ram_pipe
// Desc     : True dual-port RAM with byte enables, 1/2-cycle read latency and
//            a post-reset clearing sequencer. Define DP_RAM_PIPE_COLL_STATS_EN
//            to enable the collision pulse and saturating collision counter.
// Revision : 1.0
// ============================================================================
module dp_ram_pipe
   import dp_ram_pipe_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ADDR_WIDTH  = 4,
   parameter int                    RD_LATENCY  = 1,
   parameter int                    RDW_MODE    = 0,
   parameter int                    WR_PRIORITY = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   output logic                    busy,

   input  logic                    enA,
   input  logic                    wrA,
   input  logic [DATA_WIDTH/8-1:0] beA,
   input  logic [ADDR_WIDTH-1:0]   addrA,
   input  logic [DATA_WIDTH-1:0]   dataA_in,
   output logic [DATA_WIDTH-1:0]   dataA_out,
   output logic                    validA,

   input  logic                    enB,
   input  logic                    wrB,
   input  logic [DATA_WIDTH/8-1:0] beB,
   input  logic [ADDR_WIDTH-1:0]   addrB,
   input  logic [DATA_WIDTH-1:0]   dataB_in,
   output logic [DATA_WIDTH-1:0]   dataB_out,
   output logic                    validB,

   output logic                    coll,
   output logic [15:0]             coll_cnt
);

   localparam int DEPTH    = 2 ** ADDR_WIDTH;
   localparam int NB       = DATA_WIDTH / 8;
   localparam bit B_WINS   = (WR_PRIORITY == PRIO_B);
   localparam bit WR_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

   generate
      if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
         $fatal(1, "dp_ram_pipe: RD_LATENCY must be 1 or 2");
      end
      if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
         $fatal(1, "dp_ram_pipe: DATA_WIDTH must be a non-zero multiple of 8");
      end
   endgenerate

   init_state_e           state_q;
   logic [ADDR_WIDTH-1:0] init_ptr_q;
   logic                  busy_q;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  acc_a;
   logic                  acc_b;
   logic                  wr_a;
   logic                  wr_b;
   logic                  same_addr;
   logic [NB-1:0]         lane_a;
   logic [NB-1:0]         lane_b;
   logic [DATA_WIDTH-1:0] old_a;
   logic [DATA_WIDTH-1:0] old_b;
   logic [DATA_WIDTH-1:0] merged_a;
   logic [DATA_WIDTH-1:0] merged_b;
   logic [DATA_WIDTH-1:0] result_a;
   logic [DATA_WIDTH-1:0] result_b;

   // Init sequencer: one word cleared per cycle, then parks in READY.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= INIT;
         init_ptr_q <= '0;
         busy_q     <= 1'b1;
      end else begin
         case (state_q)
            INIT: begin
               init_ptr_q <= init_ptr_q + 1'b1;
               if (init_ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                  state_q <= READY;
                  busy_q  <= 1'b0;
               end
            end
            READY: begin
               busy_q <= 1'b0;
            end
            default: begin
               state_q <= INIT;
            end
         endcase
      end
   end

   assign busy = busy_q;

   // Each port's merged word already folds in the other port's lanes when the
   // addresses match, so both write paths agree on a same-address collision.
   always_comb begin
      acc_a     = enA & ~busy_q;
      acc_b     = enB & ~busy_q;
      wr_a      = acc_a & wrA;
      wr_b      = acc_b & wrB;
      same_addr = (addrA == addrB);
      lane_a    = {NB{wr_a}} & beA;
      lane_b    = {NB{wr_b}} & beB;
      old_a     = mem_q[addrA];
      old_b     = mem_q[addrB];
      merged_a  = old_a;
      merged_b  = old_b;
      for (int i = 0; i < NB; i++) begin
         merged_a[8*i +: 8] = merge_byte(old_a[8*i +: 8],
                                         dataA_in[8*i +: 8], lane_a[i],
                                         dataB_in[8*i +: 8], lane_b[i] & same_addr,
                                         B_WINS);
         merged_b[8*i +: 8] = merge_byte(old_b[8*i +: 8],
                                         dataA_in[8*i +: 8], lane_a[i] & same_addr,
                                         dataB_in[8*i +: 8], lane_b[i],
                                         B_WINS);
      end
      result_a = (wr_a && WR_FIRST) ? merged_a : old_a;
      result_b = (wr_b && WR_FIRST) ? merged_b : old_b;
   end

   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         mem_q[init_ptr_q] <= INIT_VALUE;
      end else begin
         if (wr_a) begin
            mem_q[addrA] <= merged_a;
         end
         if (wr_b) begin
            mem_q[addrB] <= merged_b;
         end
      end
   end

   dp_ram_pipe_outreg #(
      .DATA_WIDTH (DATA_WIDTH),
      .RD_LATENCY (RD_LATENCY)
   ) u_outreg_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .vld_in   (acc_a),
      .data_in  (result_a),
      .vld_out  (validA),
      .data_out (dataA_out)
   );

   dp_ram_pipe_outreg #(
      .DATA_WIDTH (DATA_WIDTH),
      .RD_LATENCY (RD_LATENCY)
   ) u_outreg_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .vld_in   (acc_b),
      .data_in  (result_b),
      .vld_out  (validB),
      .data_out (dataB_out)
   );

`ifdef DP_RAM_PIPE_COLL_STATS_EN
   logic        coll_q;
   logic        coll_d;
   logic [15:0] coll_cnt_q;
   logic [15:0] coll_cnt_d;

   always_comb begin
      coll_d     = acc_a & acc_b & same_addr & (wrA | wrB);
      coll_cnt_d = coll_cnt_q;
      if (coll_d && (coll_cnt_q != 16'hFFFF)) begin
         coll_cnt_d = coll_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coll_q     <= 1'b0;
         coll_cnt_q <= '0;
      end else begin
         coll_q     <= coll_d;
         coll_cnt_q <= coll_cnt_d;
      end
   end

   assign coll     = coll_q;
   assign coll_cnt = coll_cnt_q;
`else
   assign coll     = 1'b0;
   assign coll_cnt = '0;
`endif

endmodule : dp_ram_pipe
`default_nettype wire

// File: tb/tb_dp_ram_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_ram_pipe
// Desc     : Scoreboard bench for dp_ram_pipe; two configurations share one
//            stimulus stream and are checked against an array-based model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dp_ram_pipe;

   localparam int DEPTH = 16;
   localparam int CFG_LAT  [2] = '{1, 2};
   localparam int CFG_RDW  [2] = '{0, 1};
   localparam int CFG_PRIO [2] = '{1, 0};
   localparam logic [15:0] CFG_INIT [2] = '{16'h0000, 16'h5A3C};

   typedef struct packed {
      logic        en;
      logic        wr;
      logic [1:0]  be;
      logic [3:0]  addr;
      logic [15:0] data;
   } op_t;

   typedef struct {
      int          due;
      logic [15:0] data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        enA, wrA, enB, wrB;
   logic [1:0]  beA, beB;
   logic [3:0]  addrA, addrB;
   logic [15:0] dataA_in, dataB_in;

   logic        busy0, busy1, vA0, vB0, vA1, vB1, coll0, coll1;
   logic [15:0] dA0, dB0, dA1, dB1, cnt0, cnt1;

   dp_ram_pipe #(
      .DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(1), .RDW_MODE(0),
      .WR_PRIORITY(1), .INIT_VALUE(16'h0000)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .busy(busy0),
      .enA(enA), .wrA(wrA), .beA(beA), .addrA(addrA), .dataA_in(dataA_in),
      .dataA_out(dA0), .validA(vA0),
      .enB(enB), .wrB(wrB), .beB(beB), .addrB(addrB), .dataB_in(dataB_in),
      .dataB_out(dB0), .validB(vB0),
      .coll(coll0), .coll_cnt(cnt0)
   );

   dp_ram_pipe #(
      .DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(2), .RDW_MODE(1),
      .WR_PRIORITY(0), .INIT_VALUE(16'h5A3C)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .busy(busy1),
      .enA(enA), .wrA(wrA), .beA(beA), .addrA(addrA), .dataA_in(dataA_in),
      .dataA_out(dA1), .validA(vA1),
      .enB(enB), .wrB(wrB), .beB(beB), .addrB(addrB), .dataB_in(dataB_in),
      .dataB_out(dB1), .validB(vB1),
      .coll(coll1), .coll_cnt(cnt1)
   );

   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   logic        mon_en = 1'b0;
   exp_t        q [4][$];
   logic [15:0] last [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
   string       pname [4] = '{"A0", "B0", "A1", "B1"};
   logic [15:0] mem_m [2][DEPTH];
   int          init_left = DEPTH;
   logic        exp_busy = 1'b1;
   logic        exp_coll = 1'b0;
   int          exp_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic mon_port(input int p, input logic v, input logic [15:0] d);
      exp_t e;
      if (v) begin
         if (q[p].size() == 0) begin
            check({pname[p], " spurious valid"}, 32'(v), 32'd0);
         end else begin
            e = q[p].pop_front();
            check({pname[p], " latency"}, 32'(cyc), 32'(e.due));
            check({pname[p], " data"}, 32'(d), 32'(e.data));
            last[p] = e.data;
         end
      end else begin
         if (q[p].size() > 0 && q[p][0].due <= cyc) begin
            check({pname[p], " missing valid"}, 32'(v), 32'd1);
            void'(q[p].pop_front());
         end
         check({pname[p], " hold"}, 32'(d), 32'(last[p]));
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_port(0, vA0, dA0);
         mon_port(1, vB0, dB0);
         mon_port(2, vA1, dA1);
         mon_port(3, vB1, dB1);
         check("busy0", 32'(busy0), 32'(exp_busy));
         check("busy1", 32'(busy1), 32'(exp_busy));
`ifdef DP_RAM_PIPE_COLL_STATS_EN
         check("coll0", 32'(coll0), 32'(exp_coll));
         check("coll1", 32'(coll1), 32'(exp_coll));
         check("coll_cnt0", 32'(cnt0), 32'(exp_cnt));
         check("coll_cnt1", 32'(cnt1), 32'(exp_cnt));
`else
         check("coll0", 32'(coll0), 32'd0);
         check("coll_cnt1", 32'(cnt1), 32'd0);
`endif
      end
   end

   task automatic wr_lanes(input int d, input op_t o);
      if (o.en && o.wr)
         for (int i = 0; i < 2; i++)
            if (o.be[i]) mem_m[d][o.addr][8*i +: 8] = o.data[8*i +: 8];
   endtask

   // Model: capture old words, apply the losing port then the winning port.
   task automatic model(input int d, input op_t a, input op_t b,
                        output logic [15:0] oa, output logic [15:0] ob);
      logic [15:0] old_a, old_b;
      old_a = mem_m[d][a.addr];
      old_b = mem_m[d][b.addr];
      if (CFG_PRIO[d] == 1) begin
         wr_lanes(d, a);
         wr_lanes(d, b);
      end else begin
         wr_lanes(d, b);
         wr_lanes(d, a);
      end
      oa = (a.wr && CFG_RDW[d] == 1) ? mem_m[d][a.addr] : old_a;
      ob = (b.wr && CFG_RDW[d] == 1) ? mem_m[d][b.addr] : old_b;
   endtask

   task automatic drive(input logic rst, input op_t a, input op_t b);
      op_t         aa, bb;
      logic [15:0] oa, ob;
      exp_t        e;
      @(negedge clk);
      #1;
      rst_n = rst;
      enA = a.en; wrA = a.wr; beA = a.be; addrA = a.addr; dataA_in = a.data;
      enB = b.en; wrB = b.wr; beB = b.be; addrB = b.addr; dataB_in = b.data;
      if (!rst) begin
         for (int p = 0; p < 4; p++) begin
            q[p].delete();
            last[p] = 16'h0;
         end
         for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) mem_m[d][i] = CFG_INIT[d];
         init_left = DEPTH;
         exp_busy  = 1'b1;
         exp_coll  = 1'b0;
         exp_cnt   = 0;
      end else begin
         aa = a; bb = b;
         aa.en = a.en && (init_left == 0);
         bb.en = b.en && (init_left == 0);
         if (init_left > 0) init_left--;
         exp_busy = (init_left > 0);
         exp_coll = aa.en && bb.en && (a.addr == b.addr) && (a.wr || b.wr);
         if (exp_coll && exp_cnt < 65535) exp_cnt++;
         for (int d = 0; d < 2; d++) begin
            model(d, aa, bb, oa, ob);
            e.due = cyc + CFG_LAT[d];
            if (aa.en) begin e.data = oa; q[2*d].push_back(e); end
            if (bb.en) begin e.data = ob; q[2*d+1].push_back(e); end
         end
      end
   endtask

   function automatic op_t idle_op();
      return '0;
   endfunction

   function automatic op_t rd(input logic [3:0] addr);
      op_t o = '0;
      o.en = 1'b1; o.addr = addr;
      return o;
   endfunction

   function automatic op_t wr(input logic [3:0] addr, input logic [1:0] be, input logic [15:0] data);
      op_t o;
      o.en = 1'b1; o.wr = 1'b1; o.be = be; o.addr = addr; o.data = data;
      return o;
   endfunction

   function automatic op_t rnd_op();
      op_t o;
      o.en   = ($urandom_range(0, 3) != 0);
      o.wr   = $urandom_range(0, 1) == 1;
      o.be   = 2'($urandom_range(0, 3));
      o.addr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      o.data = 16'($urandom);
      return o;
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b1;
      {enA, wrA, beA, addrA, dataA_in} = '0;
      {enB, wrB, beB, addrB, dataB_in} = '0;
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTH; i++) mem_m[d][i] = CFG_INIT[d];
      #2 rst_n = 1'b0;
      mon_en = 1'b1;
      repeat (3) drive(1'b0, idle_op(), idle_op());
      // Ops during init must be dropped; reset mid-init restarts the sequence.
      repeat (7) drive(1'b1, rnd_op(), rnd_op());
      repeat (2) drive(1'b0, idle_op(), idle_op());
      repeat (16) drive(1'b1, rnd_op(), rnd_op());

      for (int i = 0; i < DEPTH; i++) drive(1'b1, rd(4'(i)), idle_op());
      drive(1'b1, wr(4'h1, 2'b11, 16'h00A1), idle_op());
      drive(1'b1, idle_op(), rd(4'h1));
      drive(1'b1, wr(4'h3, 2'b11, 16'h00C3), rd(4'h3));
      drive(1'b1, wr(4'h6, 2'b11, 16'hF6F6), wr(4'h6, 2'b01, 16'h1717));
      drive(1'b1, wr(4'h7, 2'b01, 16'h1111), wr(4'h7, 2'b10, 16'h2222));
      drive(1'b1, wr(4'h8, 2'b00, 16'hFFFF), rd(4'h8));
      drive(1'b1, rd(4'h6), rd(4'h7));
      drive(1'b1, rd(4'h3), rd(4'h8));
      repeat (4) drive(1'b1, idle_op(), rd(4'h5));

      repeat (500) drive(1'b1, rnd_op(), rnd_op());
      repeat (4) drive(1'b1, idle_op(), idle_op());
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      for (int p = 0; p < 4; p++) check({pname[p], " outstanding"}, 32'(q[p].size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_dp_ram_pipe
`default_nettype wire
